ihex_tx: RTL and testbench
==========================

// Module: ihex_tx
// PURPOSE
//  Intel HEX record encoder/transmitter; the TX-direction counterpart of the ihex receiver.
//  Takes one record request (length, address, type) and the payload bytes on a byte stream.
//  Emits the full ASCII record ":LLAAAATT<DD..>CC<EOL>" one character at a time to the UART TX.
//  Sits between the record source (e.g. memory dump/readback logic) and the UART transmitter.
// PARAMETERS
//  EOL_CRLF  1  1: terminate record with CR LF (0x0D 0x0A); 0: LF only
// PORTS
//  i_clk         in   1   clock
//  i_reset       in   1   synchronous reset, active-high
//  i_start       in   1   request one record; sampled only in IDLE
//  i_len         in   8   payload byte count LL (0..255), captured on accepted i_start
//  i_addr        in   16  record address AAAA, captured on accepted i_start
//  i_type        in   8   record type TT, captured on accepted i_start
//  i_byte        in   8   payload byte
//  i_byte_valid  in   1   i_byte valid
//  o_byte_ready  out  1   byte consumed when i_byte_valid & o_byte_ready
//  o_tx_data     out  8   ASCII character to UART
//  o_tx_stb      out  1   character valid; held with o_tx_data stable until accepted
//  i_tx_busy     in   1   UART busy; char accepted on cycle o_tx_stb & !i_tx_busy
//  o_busy        out  1   high from accepted i_start until o_done
//  o_done        out  1   one-cycle pulse after last EOL char accepted
// BEHAVIOUR
//  Reset: state IDLE; o_tx_stb=0, o_tx_data=0, o_byte_ready=0, o_busy=0, o_done=0; checksum=0.
//  Reset mid-record: abandons record; all outputs at reset values the next cycle; no partial resume.
//  States: IDLE, COLON, LEN_H, LEN_L, ADR3, ADR2, ADR1, ADR0, TYP_H, TYP_L,
//   DAT_WAIT, DAT_H, DAT_L, CS_H, CS_L, CR, LF, DONE.
//  IDLE: i_start=1 -> capture len/addr/type, sum<=0, o_busy<=1, go COLON; o_tx_stb=1 ':' next cycle.
//  Every char state: o_tx_stb=1; on acceptance advance; next char presented the following cycle.
//  Sequence: COLON -> LEN_H -> LEN_L -> ADR3..ADR0 (MS nibble first) -> TYP_H -> TYP_L.
//  After TYP_L: remaining count==0 -> CS_H; else DAT_WAIT.
//  DAT_WAIT: o_tx_stb=0, o_byte_ready=1; on i_byte_valid latch byte, count-1, go DAT_H.
//   o_byte_ready is 0 in every other state; bytes offered then are not consumed.
//  DAT_H -> DAT_L; after DAT_L: count!=0 -> DAT_WAIT, else CS_H.
//  CS_H -> CS_L -> CR (EOL_CRLF=1) or LF (EOL_CRLF=0); CR -> LF; LF -> DONE.
//  DONE: o_done=1, o_busy=0 for one cycle, then IDLE; i_start in DONE ignored.
//  i_start while o_busy ignored (not queued).
//  Hex digits: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase only).
//  Checksum: 8-bit wrap sum of LL, AAAA[15:8], AAAA[7:0], TT and every payload byte;
//   emitted CC = (~sum + 1) mod 256 (two's complement). Carries beyond 8 bits discarded.
//  Char latency with i_tx_busy=0 and data always valid: 1 char/cycle, DAT_WAIT adds 1 cycle/byte.
//  i_len=255 fully supported: 255 payload bytes, count never wraps.
// TESTING
//  EOF: len=0 addr=0000 type=01 -> ":00000001FF\r\n" (13 chars), o_byte_ready never high, o_done once.
//  Data: len=2 addr=0010 type=00 bytes AB,CD -> ":02001000ABCD76\r\n"; exactly 2 bytes consumed.
//  Wrap: len=1 addr=FFFF type=00 byte FF -> ":01FFFF00FF02\r\n" (sum 0x2FE, CC=02).
//  Backpressure: random i_tx_busy 50% -> identical char stream, o_tx_data stable while stb&busy.
//  Stall/ignore: i_byte_valid low 10 cycles in DAT_WAIT -> o_tx_stb=0 throughout;
//   i_start pulsed mid-record -> no second record emitted.
//  Reset after 5 chars -> next cycle o_tx_stb=0,o_busy=0; following EOF request emits exact 13 chars.

Source files
------------

// File: rtl/ihex_tx.sv
// Intel HEX record encoder: turns one record request plus its payload byte stream
// into the ASCII record ":LLAAAATT<DD..>CC<EOL>", presented one character at a time.
module ihex_tx #(
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_len,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_type,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  input  logic        i_tx_busy,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [4:0] {
    IDLE, COLON, LEN_H, LEN_L, ADR3, ADR2, ADR1, ADR0, TYP_H, TYP_L,
    DAT_WAIT, DAT_H, DAT_L, CS_H, CS_L, CR, LF, DONE
  } state_t;

  state_t      state;
  logic [7:0]  len_r;
  logic [15:0] addr_r;
  logic [7:0]  type_r;
  logic [3:0]  data_lo;
  logic [7:0]  count;
  logic [7:0]  sum;
  logic [7:0]  cc;
  logic        accept;

  assign cc     = ~sum + 8'd1;
  assign accept = o_tx_stb & ~i_tx_busy;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Each state names the character currently presented; the next character is
  // loaded into o_tx_data on the cycle the current one is accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      len_r        <= '0;
      addr_r       <= '0;
      type_r       <= '0;
      data_lo      <= '0;
      count        <= '0;
      sum          <= '0;
      o_tx_stb     <= 1'b0;
      o_tx_data    <= '0;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            len_r     <= i_len;
            addr_r    <= i_addr;
            type_r    <= i_type;
            count     <= i_len;
            sum       <= '0;
            o_busy    <= 1'b1;
            o_tx_stb  <= 1'b1;
            o_tx_data <= 8'h3A;
            state     <= COLON;
          end
        end
        DAT_WAIT: begin
          if (i_byte_valid) begin
            data_lo      <= i_byte[3:0];
            count        <= count - 8'd1;
            sum          <= sum + i_byte;
            o_byte_ready <= 1'b0;
            o_tx_stb     <= 1'b1;
            o_tx_data    <= hex_char(i_byte[7:4]);
            state        <= DAT_H;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (accept) begin
            case (state)
              COLON: begin
                // Header bytes are all known here, so fold them into the checksum at once.
                sum       <= len_r + addr_r[15:8] + addr_r[7:0] + type_r;
                o_tx_data <= hex_char(len_r[7:4]);
                state     <= LEN_H;
              end
              LEN_H: begin o_tx_data <= hex_char(len_r[3:0]);    state <= LEN_L; end
              LEN_L: begin o_tx_data <= hex_char(addr_r[15:12]); state <= ADR3;  end
              ADR3:  begin o_tx_data <= hex_char(addr_r[11:8]);  state <= ADR2;  end
              ADR2:  begin o_tx_data <= hex_char(addr_r[7:4]);   state <= ADR1;  end
              ADR1:  begin o_tx_data <= hex_char(addr_r[3:0]);   state <= ADR0;  end
              ADR0:  begin o_tx_data <= hex_char(type_r[7:4]);   state <= TYP_H; end
              TYP_H: begin o_tx_data <= hex_char(type_r[3:0]);   state <= TYP_L; end
              DAT_H: begin o_tx_data <= hex_char(data_lo);       state <= DAT_L; end
              TYP_L, DAT_L: begin
                if (count == 8'd0) begin
                  o_tx_data <= hex_char(cc[7:4]);
                  state     <= CS_H;
                end else begin
                  o_tx_stb     <= 1'b0;
                  o_byte_ready <= 1'b1;
                  state        <= DAT_WAIT;
                end
              end
              CS_H: begin o_tx_data <= hex_char(cc[3:0]); state <= CS_L; end
              CS_L: begin
                o_tx_data <= EOL_CRLF ? 8'h0D : 8'h0A;
                state     <= EOL_CRLF ? CR : LF;
              end
              CR: begin o_tx_data <= 8'h0A; state <= LF; end
              LF: begin
                o_tx_stb  <= 1'b0;
                o_tx_data <= '0;
                o_busy    <= 1'b0;
                o_done    <= 1'b1;
                state     <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ihex_tx.sv
// Bench for ihex_tx: drives records with random backpressure and byte gaps and
// compares the accepted character stream against a string-building reference model.
module tb_ihex_tx;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_byte_valid, i_tx_busy;
  logic [7:0]  i_len, i_type, i_byte;
  logic [15:0] i_addr;
  logic        o_byte_ready, o_tx_stb, o_busy, o_done;
  logic [7:0]  o_tx_data;

  int errors = 0;
  int checks = 0;
  byte unsigned payload_q[$];

  always #5 clk = ~clk;

  ihex_tx #(.EOL_CRLF(1'b1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
    .i_addr(i_addr), .i_type(i_type), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb),
    .i_tx_busy(i_tx_busy), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic string hex_byte(input int v);
    string hx = "0123456789ABCDEF";
    return {hx.substr((v >> 4) & 15, (v >> 4) & 15), hx.substr(v & 15, v & 15)};
  endfunction

  // Reference record text from the format rules: header, payload, two's-complement checksum, CRLF.
  function automatic string model_record(input int len, input int addr, input int typ);
    string s;
    int sum;
    sum = len + (addr >> 8) + (addr & 255) + typ;
    s = {":", hex_byte(len), hex_byte(addr >> 8), hex_byte(addr & 255), hex_byte(typ)};
    foreach (payload_q[i]) begin
      s = {s, hex_byte(payload_q[i])};
      sum += payload_q[i];
    end
    s = {s, hex_byte((256 - (sum % 256)) % 256), "\r\n"};
    return s;
  endfunction

  task automatic apply_stimulus(input logic [7:0] len, input logic [15:0] addr, input logic [7:0] typ,
                                input int busy_pct, input int valid_pct, input bit stall,
                                input bit poke_start, input string literal);
    string expected;
    byte unsigned got[$];
    int consumed = 0, done_cnt = 0, cyc = 0, stall_left;
    bit finished = 0, prev_hold = 0, extra_stb = 0;
    logic [7:0] prev_data = 8'h00;
    expected   = (literal.len() > 0) ? literal : model_record(len, addr, typ);
    stall_left = stall ? 10 : 0;
    @(negedge clk);
    check_output("idle_busy", o_busy, 1'b0);
    i_start = 1'b1; i_len = len; i_addr = addr; i_type = typ;
    @(negedge clk);
    i_start = 1'b0;
    check_output("busy_after_start", o_busy, 1'b1);
    while (!finished && cyc < 5000) begin
      if (prev_hold) begin
        check_output("hold_stb", o_tx_stb, 1'b1);
        check_output("hold_data", o_tx_data, prev_data);
      end
      if (o_done) begin
        done_cnt++;
        check_output("busy_at_done", o_busy, 1'b0);
        finished = 1;
      end
      i_tx_busy = ($urandom_range(99) < busy_pct);
      i_start   = poke_start && ($urandom_range(9) == 0);
      if (o_byte_ready && stall_left > 0) begin
        i_byte_valid = 1'b0;
        check_output("stall_stb", o_tx_stb, 1'b0);
        stall_left--;
      end else begin
        i_byte_valid = ($urandom_range(99) < valid_pct);
        i_byte = (consumed < payload_q.size()) ? payload_q[consumed] : 8'($urandom);
        if (o_byte_ready && i_byte_valid) begin
          if (consumed < payload_q.size()) consumed++;
          else check_output("extra_byte_ready", o_byte_ready, 1'b0);
        end
      end
      if (o_tx_stb && !i_tx_busy) got.push_back(o_tx_data);
      prev_hold = o_tx_stb && i_tx_busy;
      prev_data = o_tx_data;
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0; i_tx_busy = 1'b0; i_byte_valid = 1'b0;
    check_output("done_seen", finished, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (o_tx_stb) extra_stb = 1;
      if (o_done) done_cnt++;
      @(negedge clk);
    end
    check_output("no_second_record", extra_stb, 1'b0);
    check_output("done_count", done_cnt, 1);
    check_output("bytes_consumed", consumed, payload_q.size());
    check_output("char_count", got.size(), expected.len());
    for (int i = 0; i < got.size() && i < expected.len(); i++)
      check_output($sformatf("char%0d", i), got[i], expected[i]);
  endtask

  initial begin
    int accepted;
    i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_addr = '0; i_type = '0;
    i_byte = '0; i_byte_valid = 1'b0; i_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_stb", o_tx_stb, 1'b0);
    check_output("rst_data", o_tx_data, 8'h00);
    check_output("rst_ready", o_byte_ready, 1'b0);
    check_output("rst_busy", o_busy, 1'b0);
    check_output("rst_done", o_done, 1'b0);
    i_reset = 1'b0;

    payload_q = {};
    apply_stimulus(8'h00, 16'h0000, 8'h01, 0, 100, 0, 0, ":00000001FF\r\n");
    payload_q = {8'hAB, 8'hCD};
    apply_stimulus(8'h02, 16'h0010, 8'h00, 0, 100, 0, 0, ":02001000ABCD76\r\n");
    payload_q = {8'hFF};
    apply_stimulus(8'h01, 16'hFFFF, 8'h00, 0, 100, 0, 0, ":01FFFF00FF02\r\n");
    payload_q = {8'hAB, 8'hCD};
    apply_stimulus(8'h02, 16'h0010, 8'h00, 50, 100, 0, 0, ":02001000ABCD76\r\n");
    payload_q = {8'h12, 8'h34, 8'h56};
    apply_stimulus(8'h03, 16'h1234, 8'h00, 0, 100, 1, 1, "");

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 12);
      payload_q = {};
      for (int j = 0; j < n; j++) payload_q.push_back(8'($urandom));
      apply_stimulus(8'(n), 16'($urandom), 8'($urandom_range(0, 5)), 50, 70, 0, 1, "");
    end

    payload_q = {};
    for (int j = 0; j < 255; j++) payload_q.push_back(8'($urandom));
    apply_stimulus(8'hFF, 16'hC000, 8'h00, 20, 90, 0, 0, "");

    // Abandon a record after five characters, then confirm a clean restart.
    @(negedge clk);
    i_start = 1'b1; i_len = 8'h00; i_addr = 16'h0000; i_type = 8'h01;
    @(negedge clk);
    i_start = 1'b0;
    accepted = 0;
    for (int c = 0; c < 50 && accepted < 5; c++) begin
      if (o_tx_stb) accepted++;
      @(negedge clk);
    end
    check_output("pre_reset_chars", accepted, 5);
    i_reset = 1'b1;
    @(negedge clk);
    check_output("mid_rst_stb", o_tx_stb, 1'b0);
    check_output("mid_rst_busy", o_busy, 1'b0);
    check_output("mid_rst_data", o_tx_data, 8'h00);
    i_reset = 1'b0;
    payload_q = {};
    apply_stimulus(8'h00, 16'h0000, 8'h01, 0, 100, 0, 0, ":00000001FF\r\n");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
